branch_resolve_unit: RTL
========================

# branch_resolve_unit

Tracks every conditional branch from fetch until execute resolves it, compares the resolved outcome against the fetch-time prediction, and closes the prediction loop. It sits downstream of branch_history_table: it consumes `prediction` for each fetched branch and, at resolution, drives the table's write port (`en`, `write_addr`, `was_taken`, `jumped`). It also issues the pipeline flush and redirect PC on a misprediction.

## Interface
- `LOWER`, 5: width of the table index; must match branch_history_table.
- `PC_W`, 32: program counter width.
- `DEPTH`, 4: in-flight branch queue depth; power of two, at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `arst_n` input 1: synchronous, active-high reset, sampled on the `clk` rising edge. The name is kept for codebase consistency; the polarity is high.
- `if_valid` input 1: fetch slot valid.
- `if_is_branch` input 1: fetched instruction is a conditional branch.
- `if_index` input LOWER: table index used for the fetch-time lookup.
- `if_prediction` input 1: `prediction` from branch_history_table for this branch.
- `ex_valid` input 1: execute slot valid.
- `ex_is_branch` input 1: execute instruction is a conditional branch (oldest in flight).
- `ex_taken` input 1: resolved direction.
- `ex_jump` input 1: unconditional jump resolved in the same slot; counted as taken.
- `ex_pc` input PC_W: PC of the resolving instruction.
- `ex_target` input PC_W: resolved taken target.
- `fetch_stall` output 1: queue full; fetch must hold.
- `flush` output 1: one-cycle pulse on misprediction.
- `redirect_pc` output PC_W: correct next PC; valid while `flush` is high.
- `bht_en` output 1: table update strobe.
- `bht_write_addr` output LOWER: index to update.
- `bht_was_taken` output 1: resolved direction.
- `bht_jumped` output 1: registered copy of `ex_jump`.
- `branch_count` output 16: resolved branches, saturating.
- `mispredict_count` output 16: mispredictions, saturating.
- `pop_err` output 1: sticky; set when a resolution arrives with the queue empty.

## Operation
- **Queue.** A circular FIFO of DEPTH entries, each holding {index, prediction}. It uses read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits.
  - Push: `if_valid & if_is_branch & ~fetch_stall & ~flush_next`.
  - Pop: `ex_valid & (ex_is_branch | ex_jump)`, queue non-empty. Jumps are pushed by fetch as branches.
  - Pointers wrap modulo DEPTH.
  - `fetch_stall` = (count == DEPTH). It is combinational from count only.
- **Resolution.** Resolution uses the head entry.
  - actual = `ex_taken | ex_jump`.
  - mismatch = actual != head.prediction.
- **Misprediction.** On a mismatch, `flush_next` is asserted.
  - The next cycle: `flush` = 1 and `redirect_pc` = actual ? `ex_target` : `ex_pc` + 4 (modulo 2^PC_W).
  - The queue is cleared: pointers and count go to 0. Younger entries are wrong-path.
- **Simultaneous push and pop, no mismatch.** Count is unchanged and both pointers advance.
- **Simultaneous push and flush.** Flush wins and the push is dropped.
- **Pop with queue empty.** No update is issued, no flush, counters unchanged, and `pop_err` is set. Only reset clears `pop_err`.
- **Table update.** Every successful pop registers `bht_en` = 1, `bht_write_addr` = head.index, `bht_was_taken` = actual and `bht_jumped` = `ex_jump` for exactly one cycle. This happens whether or not the branch was mispredicted.
- **Counters.** `branch_count` increments on each successful pop. `mispredict_count` increments on each mismatch. Both hold at 16'hFFFF.

## Timing
- Reset, synchronous with `arst_n` = 1: the queue is emptied. All of these are 0: `flush`, `redirect_pc`, `bht_en`, `bht_write_addr`, `bht_was_taken`, `bht_jumped`, both counters, `pop_err`. `fetch_stall` = 0.
- Reset mid-operation discards all in-flight entries and any pending flush or update pulse.
- Latency, pop to `flush`/`bht_en`: 1 cycle. All outputs are registered except `fetch_stall`.
- Push to earliest pop of the same entry: 1 cycle. An entry pushed in cycle N is visible at the head in N+1.
- Back-to-back pops produce back-to-back `bht_en` pulses, one per cycle.
- A pop in the cycle where `flush` is high is still processed. The pipeline guarantees it is the correct-path instruction.

## Test plan
- **Single correct prediction.** Reset; push index 5 with prediction 1; next cycle resolve `ex_taken`=1. Expect: `bht_en`=1, `bht_write_addr`=5, `bht_was_taken`=1, `flush`=0, `branch_count`=1.
- **Mispredicted not-taken.** Push index 3 with prediction 1; resolve with `ex_taken`=0, `ex_pc`=0x40. Expect: `flush`=1 for one cycle, `redirect_pc`=0x44, `mispredict_count`=1, queue empty.
- **Full queue and stall.** Push DEPTH (4) branches with no pops. Expect: `fetch_stall`=1, a fifth push is ignored, and one pop drops `fetch_stall` to 0 the next cycle. Pop order must return indices in push order across pointer wrap (7 pushes, 7 pops).
- **Flush versus push collision.** Queue holds 2 entries; mispredict the head while `if_valid & if_is_branch` with index 9. Expect: queue empty afterwards, index 9 never appears on `bht_write_addr`.
- **Empty pop.** Assert `ex_valid`/`ex_is_branch` with the queue empty. Expect: `pop_err`=1 and held, `bht_en`=0, counters unchanged.
- **Saturation and reset.** Force 65,536 mispredictions. Expect: `mispredict_count` holds at 0xFFFF. Asserting `arst_n` mid-stream then zeroes all outputs on the next edge.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// In-flight conditional branch tracker: queues fetch-time predictions, compares them
// against execute outcomes, drives table updates and issues flush/redirect on mispredicts.
module branch_resolve_unit #(
    parameter int LOWER = 5,
    parameter int PC_W  = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             if_valid,
    input  logic             if_is_branch,
    input  logic [LOWER-1:0] if_index,
    input  logic             if_prediction,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic             ex_jump,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic [PC_W-1:0]  ex_target,
    output logic             fetch_stall,
    output logic             flush,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             bht_en,
    output logic [LOWER-1:0] bht_write_addr,
    output logic             bht_was_taken,
    output logic             bht_jumped,
    output logic [15:0]      branch_count,
    output logic [15:0]      mispredict_count,
    output logic             pop_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [LOWER-1:0] q_index [DEPTH];
    logic [DEPTH-1:0] q_pred;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic pop_req;
    logic pop_ok;
    logic queue_empty;
    logic actual;
    logic flush_next;
    logic push;

    always_comb begin
        fetch_stall = (count == FULL_COUNT);
        queue_empty = (count == '0);
        pop_req     = ex_valid & (ex_is_branch | ex_jump);
        pop_ok      = pop_req & ~queue_empty;
        actual      = ex_taken | ex_jump;
        flush_next  = pop_ok & (actual != q_pred[rd_ptr]);
        // A mispredict makes this fetch wrong-path, so it never enters the queue.
        push        = if_valid & if_is_branch & ~fetch_stall & ~flush_next;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_index[wr_ptr] <= if_index;
            q_pred[wr_ptr]  <= if_prediction;
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_next) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (arst_n) begin
            flush            <= 1'b0;
            redirect_pc      <= '0;
            bht_en           <= 1'b0;
            bht_write_addr   <= '0;
            bht_was_taken    <= 1'b0;
            bht_jumped       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
            pop_err          <= 1'b0;
        end else begin
            flush  <= flush_next;
            bht_en <= pop_ok;
            if (flush_next)
                redirect_pc <= actual ? ex_target : ex_pc + PC_W'(4);
            if (pop_ok) begin
                bht_write_addr <= q_index[rd_ptr];
                bht_was_taken  <= actual;
                bht_jumped     <= ex_jump;
                if (branch_count != '1)
                    branch_count <= branch_count + 16'd1;
            end
            if (flush_next && mispredict_count != '1)
                mispredict_count <= mispredict_count + 16'd1;
            if (pop_req && queue_empty)
                pop_err <= 1'b1;
        end
    end

endmodule
